// File: rtl/rf_pkg.sv
// rf_pkg: shared types and helpers for the multiport register file.
//   rf_clr_state_t : sweep-clear FSM state encoding
//   rf_addr_w(n)   : address width for n registers, never below 1
package rf_pkg;

    typedef enum logic {
        RF_IDLE,
        RF_SWEEP
    } rf_clr_state_t;

    function automatic int rf_addr_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: per-register write winner select and collision detect.
// Ports:
//   wr_en_i      per-port write enable
//   wr_addr_i    packed write addresses, port p at [p*ADDR_W +: ADDR_W]
//   wr_data_i    packed write data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   reg_we_o     register r is targeted by at least one in-range enabled port
//   reg_wdata_o  data of the highest-indexed port targeting register r
//   conflict_o   two or more enabled ports target the same in-range register
module rf_write_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 8,
    parameter int WRITE_PORTS   = 2,
    parameter int ADDR_W        = 3
) (
    input  logic [WRITE_PORTS-1:0]            wr_en_i,
    input  logic [WRITE_PORTS*ADDR_W-1:0]     wr_addr_i,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data_i,
    output logic [NUM_REGISTERS-1:0]          reg_we_o,
    output logic [DATA_WIDTH-1:0]             reg_wdata_o [NUM_REGISTERS],
    output logic                              conflict_o
);

    // Ports are scanned in ascending order so the last match (highest index)
    // wins; out-of-range addresses never match any register.
    always_comb begin
        conflict_o = 1'b0;
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            reg_we_o[r]    = 1'b0;
            reg_wdata_o[r] = '0;
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (wr_en_i[p] && int'(wr_addr_i[p*ADDR_W +: ADDR_W]) == r) begin
                    conflict_o     = conflict_o | reg_we_o[r];
                    reg_we_o[r]    = 1'b1;
                    reg_wdata_o[r] = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: multi-port register bank with sweep-clear.
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   wr_en_i/addr/data  independent write ports (highest index wins a collision)
//   rd_en_i/rd_addr_i  independent read ports
//   rd_data_o          read data (combinational or registered per READ_LATENCY)
//   rd_valid_o         read data valid per port
//   clear_i            start a sweep that zeroes one register per cycle
//   busy_o             sweep in progress
//   written_o          per-register written-since-reset/clear flags
//   wr_conflict_o      previous cycle had a write collision
module multiport_register_file
    import rf_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int NUM_REGISTERS = 8,
    parameter  int WRITE_PORTS   = 2,
    parameter  int READ_PORTS    = 2,
    parameter  int READ_LATENCY  = 1,
    parameter  int BYPASS        = 1,
    localparam int ADDR_W        = rf_addr_w(NUM_REGISTERS)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [WRITE_PORTS-1:0]            wr_en_i,
    input  logic [WRITE_PORTS*ADDR_W-1:0]     wr_addr_i,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data_i,
    input  logic [READ_PORTS-1:0]             rd_en_i,
    input  logic [READ_PORTS*ADDR_W-1:0]      rd_addr_i,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data_o,
    output logic [READ_PORTS-1:0]             rd_valid_o,
    input  logic                              clear_i,
    output logic                              busy_o,
    output logic [NUM_REGISTERS-1:0]          written_o,
    output logic                              wr_conflict_o
);

    logic [NUM_REGISTERS-1:0] arb_we;
    logic [DATA_WIDTH-1:0]    arb_wdata [NUM_REGISTERS];
    logic                     arb_conflict;
    logic [NUM_REGISTERS-1:0] commit;
    logic [DATA_WIDTH-1:0]    regs_q [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0]    regs_d [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] written_q, written_d;
    logic                     conflict_q;
    rf_clr_state_t            state_q, state_d;
    logic [ADDR_W-1:0]        k_q, k_d;
    logic                     sweep;

    rf_write_arbiter #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_REGISTERS(NUM_REGISTERS),
        .WRITE_PORTS  (WRITE_PORTS),
        .ADDR_W       (ADDR_W)
    ) u_arb (
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .reg_we_o   (arb_we),
        .reg_wdata_o(arb_wdata),
        .conflict_o (arb_conflict)
    );

    assign sweep         = state_q == RF_SWEEP;
    assign busy_o        = sweep;
    assign written_o     = written_q;
    assign wr_conflict_o = conflict_q;

    // Sweep-clear FSM: k walks 0..NUM_REGISTERS-1, one register per cycle.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (sweep) begin
            k_d = k_q + 1'b1;
            if (k_q == ADDR_W'(NUM_REGISTERS - 1)) begin
                state_d = RF_IDLE;
                k_d     = '0;
            end
        end else if (clear_i) begin
            state_d = RF_SWEEP;
            k_d     = '0;
        end
    end

    // During a sweep only registers already cleared (below k) accept writes;
    // the register at k is zeroed and anything above it is still pending.
    always_comb begin
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            commit[r]    = arb_we[r] && !(sweep && ADDR_W'(r) >= k_q);
            regs_d[r]    = (sweep && ADDR_W'(r) == k_q) ? '0 :
                           commit[r] ? arb_wdata[r] : regs_q[r];
            written_d[r] = (sweep && ADDR_W'(r) == k_q) ? 1'b0 : (written_q[r] | commit[r]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= RF_IDLE;
            k_q        <= '0;
            conflict_q <= 1'b0;
            written_q  <= '0;
            regs_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            conflict_q <= arb_conflict;
            written_q  <= written_d;
            regs_q     <= regs_d;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0]     addr;
        logic                  in_rng;
        logic [DATA_WIDTH-1:0] stored;

        assign addr   = rd_addr_i[p*ADDR_W +: ADDR_W];
        assign in_rng = int'(addr) < NUM_REGISTERS;
        assign stored = in_rng ? regs_q[addr] : '0;

        if (READ_LATENCY == 0) begin : g_comb
            assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = stored;
            assign rd_valid_o[p]                         = rd_en_i[p];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic                  valid_q;

            // Forwarding reuses the arbiter's winner and the sweep-filtered commit.
            assign data_d = (BYPASS != 0 && in_rng && commit[addr]) ? arb_wdata[addr] : stored;

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_en_i[p];
                    if (rd_en_i[p]) data_q <= data_d;
                end
            end

            assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
            assign rd_valid_o[p]                         = valid_q;
        end
    end

endmodule
